// File: rtl/day_time_scheduler.sv
// Day-time green/yellow/all-red sequencer: picks the next direction from lane demand,
// with starvation forcing, last-served exclusion and round-robin idle handling.
module day_time_scheduler #(
    parameter int unsigned NUM_DIRS      = 4,
    parameter int unsigned LANES_PER_DIR = 2,
    parameter int unsigned COUNT_W       = 8,
    parameter int unsigned TIMER_W       = 7,
    parameter int unsigned GREEN_PER_CAR = 1,
    parameter int unsigned MIN_GREEN     = 4,
    parameter int unsigned MAX_GREEN     = 40,
    parameter int unsigned YELLOW_TIME   = 3,
    parameter int unsigned ALL_RED_TIME  = 2,
    parameter int unsigned STARVE_LIMIT  = 3,
    localparam int unsigned NUM_LANES    = NUM_DIRS * LANES_PER_DIR,
    localparam int unsigned DIR_W        = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANES*COUNT_W-1:0]   lane_count,
    output logic [NUM_LANES-1:0]           green,
    output logic [NUM_LANES-1:0]           yellow,
    output logic [DIR_W-1:0]               cur_dir,
    output logic [TIMER_W-1:0]             green_time,
    output logic                           phase_start
);

    localparam int unsigned SUM_W  = COUNT_W + $clog2(LANES_PER_DIR);
    localparam int unsigned PROD_W = SUM_W + 32;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ALL_RED, SELECT, GREEN, YELLOW} stateT;

    stateT               state, stateNext;
    logic [TIMER_W-1:0]  timer, timerNext;
    logic [WAIT_W-1:0]   waitCnt  [NUM_DIRS];
    logic [WAIT_W-1:0]   waitNext [NUM_DIRS];
    logic                lastValid, lastValidNext;
    logic [NUM_LANES-1:0] greenNext, yellowNext;
    logic [DIR_W-1:0]    curDirNext;
    logic [TIMER_W-1:0]  greenTimeNext;
    logic                phaseStartNext;

    logic [SUM_W-1:0]    dirSum [NUM_DIRS];
    logic [SUM_W-1:0]    effSum [NUM_DIRS];
    logic [SUM_W-1:0]    bestSum;
    logic [DIR_W-1:0]    sel;
    logic                starveFound;
    logic [PROD_W-1:0]   product;
    logic [TIMER_W-1:0]  selGreenTime;

    function automatic logic [NUM_LANES-1:0] dirLanes(input logic [DIR_W-1:0] d);
        logic [NUM_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            m[i] = ((i / int'(LANES_PER_DIR)) == int'(d));
        end
        return m;
    endfunction

    // Per-direction demand, with the last served direction masked out.
    always_comb begin
        for (int d = 0; d < int'(NUM_DIRS); d++) begin
            dirSum[d] = '0;
            for (int l = 0; l < int'(LANES_PER_DIR); l++) begin
                dirSum[d] = dirSum[d]
                    + SUM_W'(lane_count[(d*int'(LANES_PER_DIR)+l)*int'(COUNT_W) +: COUNT_W]);
            end
            effSum[d] = (lastValid && (cur_dir == DIR_W'(d))) ? '0 : dirSum[d];
        end
    end

    // Starvation first, then largest demand (lowest index wins ties), then round-robin.
    always_comb begin
        sel         = '0;
        starveFound = 1'b0;
        bestSum     = '0;
        for (int d = 0; d < int'(NUM_DIRS); d++) begin
            if (!starveFound && (waitCnt[d] >= WAIT_W'(STARVE_LIMIT)) && (dirSum[d] != '0)) begin
                sel         = DIR_W'(d);
                starveFound = 1'b1;
            end
        end
        if (!starveFound) begin
            for (int d = 0; d < int'(NUM_DIRS); d++) begin
                if (effSum[d] > bestSum) begin
                    bestSum = effSum[d];
                    sel     = DIR_W'(d);
                end
            end
            if (bestSum == '0) begin
                if (!lastValid || (cur_dir == DIR_W'(NUM_DIRS - 1))) sel = '0;
                else                                                 sel = cur_dir + DIR_W'(1);
            end
        end
        product = PROD_W'(dirSum[sel]) * PROD_W'(GREEN_PER_CAR);
        if (product < PROD_W'(MIN_GREEN))      selGreenTime = TIMER_W'(MIN_GREEN);
        else if (product > PROD_W'(MAX_GREEN)) selGreenTime = TIMER_W'(MAX_GREEN);
        else                                   selGreenTime = TIMER_W'(product);
    end

    always_comb begin
        stateNext      = state;
        timerNext      = timer;
        waitNext       = waitCnt;
        lastValidNext  = lastValid;
        greenNext      = green;
        yellowNext     = yellow;
        curDirNext     = cur_dir;
        greenTimeNext  = green_time;
        phaseStartNext = 1'b0;
        case (state)
            ALL_RED: begin
                if (timer == '0) stateNext = SELECT;
                else             timerNext = timer - TIMER_W'(1);
            end
            SELECT: begin
                stateNext      = GREEN;
                timerNext      = selGreenTime - TIMER_W'(1);
                greenTimeNext  = selGreenTime;
                curDirNext     = sel;
                lastValidNext  = 1'b1;
                greenNext      = dirLanes(sel);
                phaseStartNext = 1'b1;
                for (int d = 0; d < int'(NUM_DIRS); d++) begin
                    if (DIR_W'(d) == sel)                          waitNext[d] = '0;
                    else if (waitCnt[d] < WAIT_W'(STARVE_LIMIT))   waitNext[d] = waitCnt[d] + WAIT_W'(1);
                end
            end
            GREEN: begin
                if (timer == '0) begin
                    stateNext  = YELLOW;
                    timerNext  = TIMER_W'(YELLOW_TIME - 1);
                    greenNext  = '0;
                    yellowNext = dirLanes(cur_dir);
                end else begin
                    timerNext = timer - TIMER_W'(1);
                end
            end
            YELLOW: begin
                if (timer == '0) begin
                    stateNext  = ALL_RED;
                    timerNext  = TIMER_W'(ALL_RED_TIME - 1);
                    yellowNext = '0;
                end else begin
                    timerNext = timer - TIMER_W'(1);
                end
            end
            default: stateNext = ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALL_RED;
            timer       <= TIMER_W'(ALL_RED_TIME - 1);
            waitCnt     <= '{default: '0};
            lastValid   <= 1'b0;
            green       <= '0;
            yellow      <= '0;
            cur_dir     <= '0;
            green_time  <= '0;
            phase_start <= 1'b0;
        end else begin
            state       <= stateNext;
            timer       <= timerNext;
            waitCnt     <= waitNext;
            lastValid   <= lastValidNext;
            green       <= greenNext;
            yellow      <= yellowNext;
            cur_dir     <= curDirNext;
            green_time  <= greenTimeNext;
            phase_start <= phaseStartNext;
        end
    end

endmodule

// File: tb/tb_day_time_scheduler.sv
// Directed bench for day_time_scheduler at default parameters; expected values hand-computed.
module tb_day_time_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] lane_count;
    logic [7:0]  green;
    logic [7:0]  yellow;
    logic [1:0]  cur_dir;
    logic [6:0]  green_time;
    logic        phase_start;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    day_time_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .lane_count (lane_count),
        .green      (green),
        .yellow     (yellow),
        .cur_dir    (cur_dir),
        .green_time (green_time),
        .phase_start(phase_start)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dirMask(input int d);
        logic [7:0] m;
        m = 8'h03;
        return m << (2 * d);
    endfunction

    function automatic logic [63:0] mk(input int l0, input int l1, input int l2, input int l3,
                                       input int l4, input int l5, input int l6, input int l7);
        return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    // Apply counts, wait for the next green, then measure green/yellow durations.
    task automatic runPhase(input string tag, input logic [63:0] counts, input int expDir, input int expGt);
        int n;
        lane_count = counts;
        n = 0;
        while (!phase_start && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_gap"}, 64'(n), 64'(3));
        check({tag, "_dir"}, 64'(cur_dir), 64'(expDir));
        check({tag, "_gtime"}, 64'(green_time), 64'(expGt));
        check({tag, "_green"}, 64'(green), 64'(dirMask(expDir)));
        check({tag, "_yel0"}, 64'(yellow), 64'(0));
        n = 0;
        while (green != 8'h00 && n < 300) begin
            n++;
            tick();
            if (n == 1) check({tag, "_pulse"}, 64'(phase_start), 64'(0));
        end
        check({tag, "_glen"}, 64'(n), 64'(expGt));
        check({tag, "_yellow"}, 64'(yellow), 64'(dirMask(expDir)));
        n = 0;
        while (yellow != 8'h00 && n < 300) begin
            n++;
            tick();
        end
        check({tag, "_ylen"}, 64'(n), 64'(3));
        check({tag, "_allred"}, 64'(green), 64'(0));
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_green"}, 64'(green), 64'(0));
        check({tag, "_yellow"}, 64'(yellow), 64'(0));
        check({tag, "_dir"}, 64'(cur_dir), 64'(0));
        check({tag, "_gtime"}, 64'(green_time), 64'(0));
        check({tag, "_ps"}, 64'(phase_start), 64'(0));
        for (int i = 0; i < 4; i++) check({tag, "_wait"}, 64'(dut.waitCnt[i]), 64'(0));
    endtask

    logic [63:0] base;
    logic [63:0] starve;
    int          n;

    initial begin
        rst        = 1'b1;
        base       = mk(2, 3, 10, 10, 1, 2, 4, 6);
        starve     = mk(25, 25, 25, 25, 1, 0, 25, 25);
        lane_count = base;
        tick();
        tick();
        checkReset("rst");
        rst = 1'b0;

        runPhase("largest", base, 1, 20);
        runPhase("exclude", base, 3, 10);
        runPhase("tie", mk(3, 4, 7, 0, 0, 0, 0, 0), 0, 7);
        runPhase("clamp", mk(0, 0, 60, 40, 0, 0, 0, 0), 1, 40);
        runPhase("west", mk(0, 0, 0, 0, 0, 0, 2, 3), 3, 5);
        runPhase("idle", mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 4);

        rst = 1'b1;
        tick();
        tick();
        checkReset("rst2");
        rst = 1'b0;
        runPhase("stv1", starve, 0, 40);
        runPhase("stv2", starve, 1, 40);
        runPhase("stv3", starve, 0, 40);
        runPhase("stv4", starve, 2, 4);
        check("stv_waitS", 64'(dut.waitCnt[2]), 64'(0));
        runPhase("stv5", starve, 3, 40);

        rst = 1'b1;
        tick();
        rst        = 1'b0;
        lane_count = base;
        n = 0;
        while (!phase_start && n < 300) begin
            tick();
            n++;
        end
        check("mid_dir", 64'(cur_dir), 64'(1));
        repeat (9) tick();
        check("mid_green10", 64'(green), 64'(dirMask(1)));
        rst = 1'b1;
        tick();
        checkReset("mid_rst");
        rst = 1'b0;
        runPhase("post_rst", mk(15, 15, 5, 5, 0, 0, 0, 0), 0, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
